// File: rtl/int8_fc_stream_if.sv
// Valid/ready stream bundle for the int8 FC layer: activation input stream and result output stream.
// The master side feeds activations and drains results; the slave side is the layer itself.
interface int8_fc_stream_if;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_data;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/int8_fc_stream.sv
// Streaming int8 fully-connected layer: loads IN activations, runs IN*OUT MACs on one multiplier,
// requantises (bias, rounding shift, int8 saturation) and streams OUT results.
module int8_fc_stream #(
    parameter int IN    = 8,
    parameter int OUT   = 4,
    parameter int SHIFT = 7,
    parameter int ACC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    int8_fc_stream_if.slave bus,
    output logic            busy,
    output logic            len_err
);
    localparam int IDX_W = (IN  > 1) ? $clog2(IN)  : 1;
    localparam int OIX_W = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int WGT_W = 16;
    localparam int PRD_W = 8 + WGT_W;
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(IN - 1);
    localparam logic [OIX_W-1:0] OIX_MAX = OIX_W'(OUT - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(128);

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        EMIT    = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]        idx_reg;
    logic [IDX_W-1:0]        ii_reg;
    logic [OIX_W-1:0]        oi_reg;
    logic [OIX_W-1:0]        k_reg;
    logic signed [ACC_W-1:0] acc_reg;
    logic                    in_ready_reg;
    logic                    out_valid_reg;
    logic                    out_last_reg;
    logic signed [7:0]       out_data_reg;
    logic                    busy_reg;
    logic                    len_err_reg;

    logic signed [7:0] x_mem [IN];
    logic signed [7:0] y_mem [OUT];

    logic signed [WGT_W-1:0] w_rom [OUT][IN];
    logic signed [ACC_W-1:0] b_rom [OUT];

    // Constant weight/bias tables; synthesis folds these into a small ROM feeding the MAC.
    genvar go, gi;
    generate
        for (go = 0; go < OUT; go++) begin : g_row
            for (gi = 0; gi < IN; gi++) begin : g_col
                assign w_rom[go][gi] = WGT_W'((go + 1) * (gi - 3));
            end
            if (go == 0) begin : g_b0
                assign b_rom[go] = ACC_W'(10 * (2 ** SHIFT));
            end else if (go == 1) begin : g_b1
                assign b_rom[go] = ACC_W'(-20 * (2 ** SHIFT));
            end else if (go == 2) begin : g_b2
                assign b_rom[go] = ACC_W'(5 * (2 ** SHIFT));
            end else begin : g_bz
                assign b_rom[go] = '0;
            end
        end
    endgenerate

    logic in_fire, out_fire;
    logic idx_last, ii_last, oi_last, k_last;

    assign in_fire  = bus.in_valid && in_ready_reg && (state_reg == LOAD);
    assign out_fire = out_valid_reg && bus.out_ready;
    assign idx_last = (idx_reg == IDX_MAX);
    assign ii_last  = (ii_reg == IDX_MAX);
    assign oi_last  = (oi_reg == OIX_MAX);
    assign k_last   = (k_reg == OIX_MAX);

    logic signed [7:0]       x_val;
    logic signed [WGT_W-1:0] w_val;
    logic signed [PRD_W-1:0] prod;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] rnd_val;
    logic signed [7:0]       y_new;

    assign x_val    = x_mem[ii_reg];
    assign w_val    = w_rom[oi_reg][ii_reg];
    assign prod     = PRD_W'(x_val) * PRD_W'(w_val);
    assign acc_base = (ii_reg == '0) ? b_rom[oi_reg] : acc_reg;
    assign acc_sum  = acc_base + {{(ACC_W - PRD_W){prod[PRD_W-1]}}, prod};

    // Round half up, then arithmetic shift (floors toward -inf).
    generate
        if (SHIFT == 0) begin : g_noshift
            assign rnd_val = acc_sum;
        end else begin : g_shift
            localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(2 ** (SHIFT - 1));
            assign rnd_val = (acc_sum + RND_HALF) >>> SHIFT;
        end
    endgenerate

    always_comb begin
        y_new = rnd_val[7:0];
        if (rnd_val > SAT_MAX) begin
            y_new = 8'sh7F;
        end else if (rnd_val < SAT_MIN) begin
            y_new = 8'sh80;
        end
    end

    logic [OIX_W-1:0]  k_inc;
    logic signed [7:0] y_rd;
    logic signed [7:0] y_first;

    assign k_inc   = k_last ? '0 : k_reg + 1'b1;
    assign y_rd    = y_mem[k_inc];
    // With a single output the first result is still being written on the COMPUTE->EMIT edge.
    assign y_first = (OUT == 1) ? y_new : y_mem[0];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD:    if (in_fire && idx_last) state_next = COMPUTE;
            COMPUTE: if (ii_last && oi_last)  state_next = EMIT;
            EMIT:    if (out_fire && k_last)  state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            x_mem[idx_reg] <= bus.in_data;
        end
        if (state_reg == COMPUTE && ii_last) begin
            y_mem[oi_reg] <= y_new;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= LOAD;
            idx_reg       <= '0;
            ii_reg        <= '0;
            oi_reg        <= '0;
            k_reg         <= '0;
            acc_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
            busy_reg      <= 1'b0;
            len_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= (state_next == LOAD);
            busy_reg      <= (state_next != LOAD);
            out_valid_reg <= (state_next == EMIT);

            if (in_fire) begin
                idx_reg <= idx_last ? '0 : idx_reg + 1'b1;
                if (bus.in_last != idx_last) begin
                    len_err_reg <= 1'b1;
                end
            end

            if (state_reg == COMPUTE) begin
                acc_reg <= acc_sum;
                if (ii_last) begin
                    ii_reg <= '0;
                    oi_reg <= oi_last ? '0 : oi_reg + 1'b1;
                end else begin
                    ii_reg <= ii_reg + 1'b1;
                end
                if (ii_last && oi_last) begin
                    k_reg        <= '0;
                    out_data_reg <= y_first;
                    out_last_reg <= (OUT == 1);
                end
            end

            if (state_reg == EMIT && out_fire) begin
                k_reg <= k_inc;
                if (k_last) begin
                    out_last_reg <= 1'b0;
                end else begin
                    out_data_reg <= y_rd;
                    out_last_reg <= (k_inc == OIX_MAX);
                end
            end
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_last  = out_last_reg;
    assign busy          = busy_reg;
    assign len_err       = len_err_reg;
endmodule

// File: tb/tb_int8_fc_stream.sv
// Directed bench for int8_fc_stream: a default instance and a SHIFT=0 instance share one stimulus stream.
module tb_int8_fc_stream;
    localparam int IN  = 8;
    localparam int OUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy_a, len_err_a, busy_s, len_err_s;

    int8_fc_stream_if ifa();
    int8_fc_stream_if ifs();

    int8_fc_stream #(.IN(IN), .OUT(OUT), .SHIFT(7), .ACC_W(32)) u_dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifa.slave),
        .busy    (busy_a),
        .len_err (len_err_a)
    );

    int8_fc_stream #(.IN(IN), .OUT(OUT), .SHIFT(0), .ACC_W(32)) u_sat (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifs.slave),
        .busy    (busy_s),
        .len_err (len_err_s)
    );

    assign ifs.in_valid  = ifa.in_valid;
    assign ifs.in_data   = ifa.in_data;
    assign ifs.in_last   = ifa.in_last;
    assign ifs.out_ready = ifa.out_ready;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int failures = 0;
    int e_cyc, lat, stab_err, rdy_err, silent_valid;

    logic signed [7:0] vec   [IN];
    logic signed [7:0] got_a [OUT];
    logic signed [7:0] got_s [OUT];
    logic              got_last [OUT];
    logic signed [7:0] exp_a [OUT];
    logic signed [7:0] exp_s [OUT];

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  ifa.in_ready,  1);
        check({tag, "_out_valid"}, ifa.out_valid, 0);
        check({tag, "_out_last"},  ifa.out_last,  0);
        check({tag, "_out_data"},  ifa.out_data,  0);
        check({tag, "_busy"},      busy_a,        0);
        check({tag, "_len_err"},   len_err_a,     0);
    endtask

    // Streams vec; in_last on beat last_pos. With junk set, keeps presenting a bogus beat while busy.
    task automatic send_vec(input int last_pos, input bit gaps, input bit junk);
        for (int i = 0; i < IN; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    ifa.in_valid = 1'b0;
                    @(negedge clk);
                end
            end
            ifa.in_valid = 1'b1;
            ifa.in_data  = vec[i];
            ifa.in_last  = (i == last_pos);
            for (int g = 0; g < 100 && !ifa.in_ready; g++) @(negedge clk);
            @(negedge clk);
        end
        e_cyc        = cyc;
        ifa.in_valid = junk;
        ifa.in_data  = 8'sd99;
        ifa.in_last  = 1'b0;
    endtask

    task automatic wait_first(input string tag);
        int g;
        for (g = 0; g < 200 && !ifa.out_valid; g++) begin
            if (ifa.in_ready || !busy_a) rdy_err++;
            @(negedge clk);
        end
        lat = cyc - e_cyc + 1;
        check({tag, "_latency"}, lat, IN * OUT + 1);
    endtask

    // Collects one output frame; bp selects the 1,0,0 ready pattern.
    task automatic recv_frame(input string tag, input bit bp);
        int n = 0;
        int g;
        logic stall = 1'b0;
        logic signed [7:0] hold = '0;
        for (g = 0; g < 300 && n < OUT; g++) begin
            ifa.out_ready = bp ? ((g % 3) == 0) : 1'b1;
            if (stall && ifa.out_data !== hold) stab_err++;
            if (ifa.out_valid && (ifa.in_ready || !busy_a)) rdy_err++;
            if (ifa.out_valid && ifa.out_ready) begin
                got_a[n]    = ifa.out_data;
                got_s[n]    = ifs.out_data;
                got_last[n] = ifa.out_last;
                n++;
                if (n == OUT) ifa.in_valid = 1'b0;
            end
            stall = ifa.out_valid && !ifa.out_ready;
            hold  = ifa.out_data;
            @(negedge clk);
        end
        ifa.out_ready = 1'b1;
        check({tag, "_beats"}, n, OUT);
        check({tag, "_in_ready_after"}, ifa.in_ready, 1);
    endtask

    task automatic check_frame(input string tag, input bit with_sat);
        for (int k = 0; k < OUT; k++) begin
            check($sformatf("%s_y%0d", tag, k), got_a[k], exp_a[k]);
            check($sformatf("%s_last%0d", tag, k), got_last[k], (k == OUT - 1));
            if (with_sat) check($sformatf("%s_sat_y%0d", tag, k), got_s[k], exp_s[k]);
        end
    endtask

    initial begin
        ifa.in_valid  = 1'b0;
        ifa.in_data   = '0;
        ifa.in_last   = 1'b0;
        ifa.out_ready = 1'b1;
        stab_err      = 0;
        rdy_err       = 0;

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("reset");

        // Nominal frame, out_ready held high
        vec   = '{8'sd10, -8'sd3, 8'sd7, 8'sd2, -8'sd8, 8'sd1, 8'sd4, -8'sd2};
        exp_a = '{8'sd10, -8'sd21, 8'sd4, -8'sd1};
        exp_s = '{-8'sd23, -8'sd86, -8'sd94, 8'sh80};
        send_vec(IN - 1, 1'b0, 1'b1);
        wait_first("nom");
        recv_frame("nom", 1'b0);
        check_frame("nom", 1'b1);
        check("nom_len_err", len_err_a, 0);
        $display("[TB] nominal frame: %0d %0d %0d %0d", got_a[0], got_a[1], got_a[2], got_a[3]);

        // Backpressure with ready pattern 1,0,0
        send_vec(IN - 1, 1'b0, 1'b1);
        wait_first("bp");
        recv_frame("bp", 1'b1);
        check_frame("bp", 1'b0);
        check("bp_stable", stab_err, 0);
        check("bp_in_ready_low", rdy_err, 0);
        $display("[TB] backpressure frame: %0d %0d %0d %0d", got_a[0], got_a[1], got_a[2], got_a[3]);

        // Saturation on the SHIFT=0 instance
        vec   = '{8'sh80, 8'sh80, 8'sh80, 8'sd0, 8'sd127, 8'sd127, 8'sd127, 8'sd127};
        exp_s = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
        send_vec(IN - 1, 1'b0, 1'b1);
        wait_first("satp");
        recv_frame("satp", 1'b0);
        for (int k = 0; k < OUT; k++) check($sformatf("satp_y%0d", k), got_s[k], exp_s[k]);
        $display("[TB] sat+ frame: %0d %0d %0d %0d", got_s[0], got_s[1], got_s[2], got_s[3]);

        vec   = '{8'sd127, 8'sd127, 8'sd127, 8'sd0, 8'sh80, 8'sh80, 8'sh80, 8'sh80};
        exp_s = '{8'sh80, 8'sh80, 8'sh80, 8'sh80};
        send_vec(IN - 1, 1'b0, 1'b1);
        wait_first("satn");
        recv_frame("satn", 1'b0);
        for (int k = 0; k < OUT; k++) check($sformatf("satn_y%0d", k), got_s[k], exp_s[k]);
        $display("[TB] sat- frame: %0d %0d %0d %0d", got_s[0], got_s[1], got_s[2], got_s[3]);

        // Framing error: in_last on beat 5, absent on beat 8
        vec   = '{8'sd10, -8'sd3, 8'sd7, 8'sd2, -8'sd8, 8'sd1, 8'sd4, -8'sd2};
        send_vec(4, 1'b0, 1'b1);
        wait_first("frm");
        recv_frame("frm", 1'b0);
        check_frame("frm", 1'b0);
        check("frm_len_err", len_err_a, 1);
        send_vec(IN - 1, 1'b0, 1'b1);
        wait_first("frm2");
        recv_frame("frm2", 1'b0);
        check_frame("frm2", 1'b0);
        check("frm_len_err_sticky", len_err_a, 1);
        $display("[TB] framing error: len_err=%0d", len_err_a);

        // Reset 10 cycles into COMPUTE aborts the frame
        send_vec(IN - 1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        silent_valid = 0;
        repeat (40) begin
            if (ifa.out_valid) silent_valid++;
            @(negedge clk);
        end
        check("midrst_no_output", silent_valid, 0);
        send_vec(IN - 1, 1'b0, 1'b1);
        wait_first("rerun");
        recv_frame("rerun", 1'b0);
        check_frame("rerun", 1'b0);
        $display("[TB] after mid-compute reset: %0d %0d %0d %0d", got_a[0], got_a[1], got_a[2], got_a[3]);

        // Random input gaps over two consecutive vectors
        for (int f = 0; f < 2; f++) begin
            send_vec(IN - 1, 1'b1, 1'b1);
            wait_first($sformatf("gap%0d", f));
            recv_frame($sformatf("gap%0d", f), 1'b0);
            check_frame($sformatf("gap%0d", f), 1'b0);
            $display("[TB] gap frame %0d: %0d %0d %0d %0d", f, got_a[0], got_a[1], got_a[2], got_a[3]);
        end
        check("busy_in_ready_low", rdy_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule
